// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, result classes, PSR layout and the
// decode helpers used by both the ALU and the writeback stage.
package alu_pkg;

  localparam int PSR_W  = 5;
  localparam int REG_W  = 16;
  localparam int ADDR_W = 4;

  localparam int PSR_C = 4;
  localparam int PSR_F = 3;
  localparam int PSR_L = 2;
  localparam int PSR_N = 1;
  localparam int PSR_Z = 0;

  localparam logic [7:0] OP_ADD   = 8'd0;
  localparam logic [7:0] OP_ADDU  = 8'd1;
  localparam logic [7:0] OP_ADDC  = 8'd2;
  localparam logic [7:0] OP_ADDCU = 8'd3;
  localparam logic [7:0] OP_ADDI  = 8'd4;
  localparam logic [7:0] OP_ADDIU = 8'd5;
  localparam logic [7:0] OP_SUBU  = 8'd6;
  localparam logic [7:0] OP_MUL   = 8'd7;
  localparam logic [7:0] OP_SUB   = 8'd8;
  localparam logic [7:0] OP_SUBC  = 8'd9;
  localparam logic [7:0] OP_CMP   = 8'd10;
  localparam logic [7:0] OP_CMPU  = 8'd11;
  localparam logic [7:0] OP_CMPI  = 8'd12;
  localparam logic [7:0] OP_CMPIU = 8'd13;
  localparam logic [7:0] OP_AND   = 8'd14;
  localparam logic [7:0] OP_OR    = 8'd15;
  localparam logic [7:0] OP_XOR   = 8'd16;
  localparam logic [7:0] OP_NOT   = 8'd17;
  localparam logic [7:0] OP_SLL   = 8'd18;
  localparam logic [7:0] OP_SRL   = 8'd19;
  localparam logic [7:0] OP_SRA   = 8'd20;
  localparam logic [7:0] OP_ROL   = 8'd21;
  localparam logic [7:0] OP_ROR   = 8'd22;
  localparam logic [7:0] OP_LUI   = 8'd23;
  localparam logic [7:0] OP_NOP   = 8'd24;

  typedef enum logic [2:0] {
    CLS_ARITH    = 3'd0,
    CLS_UNSIGNED = 3'd1,
    CLS_CMP      = 3'd2,
    CLS_LOGIC    = 3'd3,
    CLS_NOP      = 3'd4,
    CLS_ILLEGAL  = 3'd5
  } op_class_e;

  typedef struct packed {
    logic [7:0]        opcode;
    logic [ADDR_W-1:0] dest;
    logic [REG_W-1:0]  result;
    logic              carry;
    logic              flag;
    logic              low;
  } wb_entry_t;

  function automatic op_class_e decode_class(input logic [7:0] op);
    op_class_e cls;
    case (op) inside
      OP_ADD, OP_ADDC, OP_ADDI, OP_MUL, OP_SUB, OP_SUBC: cls = CLS_ARITH;
      OP_ADDU, OP_ADDCU, OP_ADDIU, OP_SUBU:              cls = CLS_UNSIGNED;
      [OP_CMP:OP_CMPIU]:                                 cls = CLS_CMP;
      [OP_AND:OP_LUI]:                                   cls = CLS_LOGIC;
      OP_NOP:                                            cls = CLS_NOP;
      default:                                           cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic is_write_class(input op_class_e cls);
    logic wr;
    case (cls)
      CLS_ARITH, CLS_UNSIGNED, CLS_LOGIC: wr = 1'b1;
      default:                            wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Bundle between the ALU/issue side and the writeback stage: result handshake,
// operand read ports, flags and commit report.
interface alu_writeback_if;
  import alu_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [7:0]           in_opcode;
  logic [ADDR_W-1:0]    in_dest;
  logic [REG_W-1:0]     in_result;
  logic                 in_carry;
  logic                 in_flag;
  logic                 in_low;
  logic                 stall;
  logic [ADDR_W-1:0]    rd_addr_a;
  logic [ADDR_W-1:0]    rd_addr_b;
  logic [REG_W-1:0]     rd_data_a;
  logic [REG_W-1:0]     rd_data_b;
  logic [PSR_W-1:0]     psr;
  logic                 carry_out;
  logic                 wb_valid;
  logic [ADDR_W-1:0]    wb_dest;
  logic [REG_W-1:0]     wb_data;
  logic                 illegal_op;

  modport master (
    output in_valid, in_opcode, in_dest, in_result, in_carry, in_flag, in_low,
           stall, rd_addr_a, rd_addr_b,
    input  in_ready, rd_data_a, rd_data_b, psr, carry_out,
           wb_valid, wb_dest, wb_data, illegal_op
  );

  modport slave (
    input  in_valid, in_opcode, in_dest, in_result, in_carry, in_flag, in_low,
           stall, rd_addr_a, rd_addr_b,
    output in_ready, rd_data_a, rd_data_b, psr, carry_out,
           wb_valid, wb_dest, wb_data, illegal_op
  );
endinterface

// File: rtl/regfile_16x16.sv
// 16 x 16-bit register file: one synchronous write port, two combinational
// read ports with no write-through bypass.
module regfile_16x16
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [REG_W-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [REG_W-1:0]  o_rdata_a,
  output logic [REG_W-1:0]  o_rdata_b
);

  logic [REG_W-1:0] r_mem [16];

  // Register array storage; r0 is an ordinary writable register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= 16'h0000;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-entry pipe register that commits results into the
// register file and updates the PSR by opcode class.
module alu_writeback
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  alu_writeback_if.slave bus
);

  wb_entry_t          r_pipe;
  logic               r_pipe_full;
  logic [PSR_W-1:0]   r_psr;
  logic               r_illegal;

  logic               w_commit_now;
  logic               w_commit;
  logic               w_accept;
  logic               w_write;
  op_class_e          w_cls;
  logic               w_z;
  logic               w_n;
  logic [PSR_W-1:0]   w_psr_next;

  // Ready ignores reset so it reads !stall while the pipe is being flushed.
  assign w_commit_now = r_pipe_full & ~bus.stall;
  assign bus.in_ready = ~bus.stall & (~r_pipe_full | w_commit_now);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_commit     = w_commit_now & ~reset;

  assign w_cls   = decode_class(r_pipe.opcode);
  assign w_write = w_commit & is_write_class(w_cls);
  assign w_z     = (r_pipe.result == 16'h0000);
  assign w_n     = r_pipe.result[15];

  // Per-class PSR update; untouched bits keep their value.
  always_comb begin
    w_psr_next = r_psr;
    case (w_cls)
      CLS_ARITH: begin
        w_psr_next[PSR_F] = r_pipe.flag;
        w_psr_next[PSR_Z] = w_z;
        w_psr_next[PSR_N] = w_n;
      end
      CLS_UNSIGNED: begin
        w_psr_next[PSR_C] = r_pipe.carry;
        w_psr_next[PSR_Z] = w_z;
        w_psr_next[PSR_N] = w_n;
      end
      CLS_CMP: begin
        w_psr_next[PSR_L] = r_pipe.low;
      end
      CLS_LOGIC: begin
        w_psr_next[PSR_Z] = w_z;
        w_psr_next[PSR_N] = w_n;
      end
      default: begin
        w_psr_next = r_psr;
      end
    endcase
  end

  // Pipe register, PSR and sticky illegal flag; reset beats accept and commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe      <= '0;
      r_pipe_full <= 1'b0;
      r_psr       <= 5'b00000;
      r_illegal   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pipe      <= '{opcode: bus.in_opcode, dest: bus.in_dest,
                         result: bus.in_result, carry: bus.in_carry,
                         flag: bus.in_flag, low: bus.in_low};
        r_pipe_full <= 1'b1;
      end else if (w_commit) begin
        r_pipe_full <= 1'b0;
      end
      if (w_commit) begin
        r_psr <= w_psr_next;
        if (w_cls == CLS_ILLEGAL) begin
          r_illegal <= 1'b1;
        end
      end
    end
  end

  regfile_16x16 u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_write),
    .i_waddr   (r_pipe.dest),
    .i_wdata   (r_pipe.result),
    .i_raddr_a (bus.rd_addr_a),
    .i_raddr_b (bus.rd_addr_b),
    .o_rdata_a (bus.rd_data_a),
    .o_rdata_b (bus.rd_data_b)
  );

  assign bus.wb_valid   = w_write;
  assign bus.wb_dest    = r_pipe.dest;
  assign bus.wb_data    = r_pipe.result;
  assign bus.psr        = r_psr;
  assign bus.carry_out  = r_psr[PSR_C];
  assign bus.illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: expected commits go into a scoreboard
// queue that a negedge monitor drains against wb_valid/wb_dest/wb_data.
module tb_alu_writeback;

  typedef struct {
    logic [3:0]  dest;
    logic [15:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   n_wb;
  exp_t q[$];

  alu_writeback_if bus ();

  alu_writeback dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #90000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk_psr(input string name, input logic [4:0] exp);
    n_cmp++;
    if (bus.psr !== exp) begin
      n_fail++;
      $display("FAIL %s: got psr %b, expected %b", name, bus.psr, exp);
    end
  endtask

  task automatic rd_chk(input string name, input logic [3:0] addr, input logic [15:0] exp);
    bus.rd_addr_b = addr;
    #1;
    chk16(name, bus.rd_data_b, exp);
  endtask

  // Scoreboard monitor: every committed write must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.wb_valid === 1'b1) begin
      exp_t e;
      n_wb++;
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wb_unexpected: got dest %0d data %h, expected no commit",
                 bus.wb_dest, bus.wb_data);
      end else begin
        e = q.pop_front();
        chk16("wb_dest", {12'h000, bus.wb_dest}, {12'h000, e.dest});
        chk16("wb_data", bus.wb_data, e.data);
      end
    end
  end

  // Offers one result; returns 1 ns after the accepting edge.
  task automatic send(input logic [7:0] op, input logic [3:0] dest, input logic [15:0] res,
                      input logic c, input logic f, input logic l, input logic exp_w);
    int budget;
    bus.in_opcode = op;
    bus.in_dest   = dest;
    bus.in_result = res;
    bus.in_carry  = c;
    bus.in_flag   = f;
    bus.in_low    = l;
    bus.in_valid  = 1'b1;
    if (exp_w) q.push_back('{dest, res});
    @(negedge clk);
    budget = 0;
    while (bus.in_ready !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk1("in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    chk1("rst_wb_valid", bus.wb_valid, 1'b0);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int n0;
    n_cmp = 0; n_fail = 0; n_wb = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_opcode = 8'd0; bus.in_dest = 4'd0;
    bus.in_result = 16'h0000; bus.in_carry = 1'b0; bus.in_flag = 1'b0;
    bus.in_low = 1'b0; bus.stall = 1'b0; bus.rd_addr_a = 4'd0; bus.rd_addr_b = 4'd0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk1("rst_wb_valid0", bus.wb_valid, 1'b0);
    chk1("rst_in_ready0", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_psr("rst_psr", 5'b00000);
    chk1("rst_illegal", bus.illegal_op, 1'b0);
    chk1("rst_carry_out", bus.carry_out, 1'b0);
    for (int i = 0; i < 16; i++) rd_chk("rst_reg", 4'(i), 16'h0000);
    @(posedge clk);
    #1;

    // ADDU dest 3, zero result, carry in
    send(8'd1, 4'd3, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk1("addu_wb_valid", bus.wb_valid, 1'b1);
    @(posedge clk);
    #1;
    chk_psr("addu_psr", 5'b10001);
    chk1("addu_carry_out", bus.carry_out, 1'b1);
    rd_chk("addu_r3", 4'd3, 16'h0000);

    // Back-to-back ADD then AND
    do_reset();
    n0 = n_wb;
    send(8'd0, 4'd1, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    send(8'd14, 4'd2, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    chk16("b2b_commits", 16'(n_wb - n0), 16'd2);
    chk_psr("b2b_psr", 5'b01000);
    rd_chk("b2b_r1", 4'd1, 16'h8000);
    rd_chk("b2b_r2", 4'd2, 16'h0001);

    // CMP held by stall for three cycles
    do_reset();
    bus.in_opcode = 8'd10; bus.in_dest = 4'd6; bus.in_result = 16'h5555;
    bus.in_carry = 1'b0; bus.in_flag = 1'b0; bus.in_low = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("stall_wb_valid", bus.wb_valid, 1'b0);
      chk1("stall_in_ready", bus.in_ready, 1'b0);
      @(posedge clk);
    end
    #1;
    bus.stall = 1'b0;
    chk_psr("stall_psr_held", 5'b00000);
    @(negedge clk);
    chk1("cmp_wb_valid", bus.wb_valid, 1'b0);
    @(posedge clk);
    #1;
    chk_psr("cmp_psr", 5'b00100);
    rd_chk("cmp_r6", 4'd6, 16'h0000);

    // Illegal opcode 200, then NOP keeps sticky flag
    send(8'd200, 4'd4, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk1("ill_before", bus.illegal_op, 1'b0);
    @(posedge clk);
    #1;
    chk1("ill_after", bus.illegal_op, 1'b1);
    chk_psr("ill_psr", 5'b00100);
    rd_chk("ill_r4", 4'd4, 16'h0000);
    send(8'd24, 4'd9, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk1("ill_sticky", bus.illegal_op, 1'b1);
    chk_psr("nop_psr", 5'b00100);
    rd_chk("nop_r9", 4'd9, 16'h0000);
    do_reset();
    chk1("ill_cleared", bus.illegal_op, 1'b0);

    // No bypass on read of the register being committed
    send(8'd8, 4'd5, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b1);
    send(8'd8, 4'd5, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.rd_addr_a = 4'd5;
    @(negedge clk);
    chk16("nobypass_old", bus.rd_data_a, 16'hAAAA);
    @(posedge clk);
    #1;
    chk16("nobypass_new", bus.rd_data_a, 16'h1234);
    chk_psr("sub_psr", 5'b00000);

    // Reset discards pending OR
    send(8'd15, 4'd7, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    rd_chk("flush_r7", 4'd7, 16'h0000);
    chk_psr("flush_psr", 5'b00000);
    @(negedge clk);
    chk1("flush_wb_valid", bus.wb_valid, 1'b0);
    @(posedge clk);
    #1;

    // Reset beats a simultaneous accept
    bus.in_opcode = 8'd15; bus.in_dest = 4'd7; bus.in_result = 16'hFFFF;
    bus.in_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk1("rstwin_wb_valid", bus.wb_valid, 1'b0);
    @(posedge clk);
    #1;
    rd_chk("rstwin_r7", 4'd7, 16'h0000);
    chk_psr("rstwin_psr", 5'b00000);

    chk16("sb_empty", 16'(q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
